// File: rtl/cpu_tick_controller.sv
// Run/halt/single-step controller producing the Tick/ClockEnable strobes for the CPU state registers.
// Tick is a registered one-cycle pulse every Div+1 Clock cycles while running; a PC breakpoint can stop it.
module cpu_tick_controller #(
    parameter int DIV_W     = 8,
    parameter int CNT_W     = 32,
    parameter bit START_RUN = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Halt,
    input  logic             Step,
    input  logic [DIV_W-1:0] Div,
    input  logic             BreakEn,
    input  logic [31:0]      BreakAddr,
    input  logic [31:0]      PC,
    output logic             Tick,
    output logic             ClockEnable,
    output logic             Running,
    output logic             Halted,
    output logic             BreakHit,
    output logic [CNT_W-1:0] CycleCount,
    output logic [1:0]       DebugState
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_BREAK  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALTED;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] prescaler_q, prescaler_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic             tick_q;
    logic             resume_q, resume_d;
    logic             run_prev_q, halt_prev_q, step_prev_q;
    logic             run_edge, halt_edge, step_edge;
    logic             at_compare;
    logic             break_match;
    logic             issue_tick;

    // Edges act on the same Clock edge that first samples the input high.
    assign run_edge    = Run  & ~run_prev_q;
    assign halt_edge   = Halt & ~halt_prev_q;
    assign step_edge   = Step & ~step_prev_q;
    assign at_compare  = (prescaler_q == Div);
    assign break_match = BreakEn && (PC == BreakAddr) && !resume_q;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q       <= RESET_STATE;
            prescaler_q   <= '0;
            cycle_count_q <= '0;
            tick_q        <= 1'b0;
            resume_q      <= 1'b0;
            run_prev_q    <= 1'b0;
            halt_prev_q   <= 1'b0;
            step_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            resume_q    <= resume_d;
            tick_q      <= issue_tick;
            run_prev_q  <= Run;
            halt_prev_q <= Halt;
            step_prev_q <= Step;
            if (issue_tick) begin
                cycle_count_q <= cycle_count_q + 1'b1;
            end
        end
    end

    // Priority among simultaneous edges is Halt > Step > Run in every state.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        resume_d    = resume_q;
        issue_tick  = 1'b0;
        case (state_q)
            ST_HALTED: begin
                prescaler_d = '0;
                resume_d    = 1'b0;
                if (halt_edge) begin
                    state_d = ST_HALTED;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                end else if (run_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_edge) begin
                    state_d     = ST_HALTED;
                    prescaler_d = '0;
                    resume_d    = 1'b0;
                end else if (at_compare) begin
                    prescaler_d = '0;
                    resume_d    = 1'b0;
                    if (break_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        issue_tick = 1'b1;
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end
            ST_STEP: begin
                resume_d = 1'b0;
                if (halt_edge) begin
                    state_d     = ST_HALTED;
                    prescaler_d = '0;
                end else if (at_compare) begin
                    state_d     = ST_HALTED;
                    prescaler_d = '0;
                    issue_tick  = 1'b1;
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end
            ST_BREAK: begin
                prescaler_d = '0;
                resume_d    = 1'b0;
                if (halt_edge) begin
                    state_d = ST_HALTED;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                end else if (run_edge) begin
                    // Let the first Tick of this run retire the breakpoint instruction.
                    state_d  = ST_RUN;
                    resume_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_HALTED;
                prescaler_d = '0;
                resume_d    = 1'b0;
            end
        endcase
    end

    assign Tick        = tick_q;
    assign CycleCount  = cycle_count_q;
    assign ClockEnable = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign Running     = (state_q == ST_RUN);
    assign Halted      = (state_q == ST_HALTED) || (state_q == ST_BREAK);
    assign BreakHit    = (state_q == ST_BREAK);
    assign DebugState  = state_q;

endmodule
